operand_fetch_unit: RTL
=======================

Name: operand_fetch_unit

Overview:
- Responder side of the fetch_row / fetch_col / fetch_stall interface driven by the matrix-multiplier control unit.
- On a fetch_row request, gathers row n of matrix A (K elements) from word-addressed memory into a row buffer.
- On a fetch_col request, gathers column m of matrix B (K elements, strided) into a column buffer.
- Holds fetch_stall high until the requested operands are complete, then presents them to the PE array.

Parameters:
N, 4, rows of A / result rows
M, 4, columns of B / result columns
K, 4, inner dimension (elements per row of A and per column of B)
DATA_WIDTH, 8, element width
ADDR_WIDTH, 16, memory word-address width
A_BASE, 0, word address of A[0][0]; A is row-major N x K
B_BASE, 256, word address of B[0][0]; B is row-major K x M

Ports:
clk  in  1  clock; one clock
rst  in  1  reset is synchronous and active-high
fetch_row  in  1  request row n of A; held by initiator until accepted
fetch_col  in  1  request column m of B; held by initiator until accepted
n  in  $clog2(N) (min 1)  row index, sampled at acceptance
m  in  $clog2(M) (min 1)  column index, sampled at acceptance
fetch_stall  out  1  busy; a request is accepted on a cycle where fetch_stall=0
mem_req  out  1  memory read request
mem_addr  out  ADDR_WIDTH  read word address
mem_gnt  in  1  request accepted this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  read data valid; responses return in order, latency >= 1
mem_rdata  in  DATA_WIDTH  read data
row_data  out  K*DATA_WIDTH  row buffer; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
row_valid  out  1  row buffer complete
col_data  out  K*DATA_WIDTH  column buffer, same packing
col_valid  out  1  column buffer complete
protocol_err  out  1  sticky: mem_rvalid with no outstanding read

Behaviour:
- Reset (synchronous, active-high): all outputs 0, both buffers 0, state IDLE, all counters 0, pending flag cleared. A reset mid-transfer abandons the transfer.
- fetch_stall = (state != IDLE) | pending_col. The signal is registered-state based; it has no combinational path from fetch_* inputs.
- States:
  - IDLE: fetch_row accepted -> latch n, clear row_valid, go ISSUE (target=ROW). Else fetch_col accepted -> latch m, clear col_valid, go ISSUE (target=COL).
  - Both requests asserted in the same cycle: accept both. Row is served first; m is latched into pending_col and col_valid is cleared.
  - ISSUE: mem_req=1. mem_addr = A_BASE + n*K + k_iss (ROW) or B_BASE + k_iss*M + m (COL), computed modulo 2^ADDR_WIDTH. k_iss increments on mem_gnt. A grant on k_iss=K-1 -> WAIT.
  - WAIT: mem_req=0. When k_rcv reaches K -> set row_valid or col_valid, then go ISSUE (target=COL) if pending_col, else IDLE.
- Receive side (ISSUE and WAIT):
  - mem_rvalid writes mem_rdata into element k_rcv of the target buffer and increments k_rcv.
  - Each response counts as outstanding from grant to rvalid. A grant and an rvalid in the same cycle are both counted.
- Latency: for memory latency L with mem_gnt held high, the valid flag rises K+L cycles after acceptance. fetch_stall falls on the same edge.
- mem_rvalid with outstanding=0: data is discarded and protocol_err is set. protocol_err clears only on rst.
- Buffer contents are stable whenever the corresponding valid=1. A buffer is overwritten only after a new request for it is accepted.
- Requests asserted while fetch_stall=1 are not accepted and have no effect. The initiator holds them.
- N=1 or M=1: index ports are 1 bit wide and tied to 0 by the user.

Decomposition:
- Shared package mm_pkg:
  - fetch_state_t enum {IDLE, ISSUE, WAIT}
  - fetch_target_t enum {ROW, COL}
  - index-width helper function shared with the control unit.
- One sub-module: fetch_addr_gen. It is a combinational address computation (base + major*stride + minor) with a width-truncation rule, instantiated once with muxed operands.

Test Plan:
1. Reset, then fetch_row with n=2, K=4, A_BASE=0, memory latency 1, gnt always 1 -> mem_addr sequence 8,9,10,11. row_valid rises 5 cycles after acceptance and row_data equals mem[8..11].
2. fetch_col with m=3, M=4, B_BASE=256 -> mem_addr sequence 259,263,267,271. col_valid rises and fetch_stall drops on the same edge.
3. fetch_row and fetch_col in the same cycle (n=1, m=0) -> row addresses 4..7 are issued first, then column addresses 256,260,264,268. fetch_stall stays high throughout. row_valid rises before col_valid.
4. Random mem_gnt backpressure with latency 3 -> exactly K grants and no extra mem_req after the last grant. Buffer order is preserved and protocol_err=0.
5. rst asserted mid-ISSUE -> the next cycle shows all outputs 0 and IDLE. A new fetch_row completes correctly.
6. Spurious mem_rvalid in IDLE -> protocol_err=1 and stays 1. Buffers are unchanged.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiplier datapath.
//   fetch_state_t  : operand fetch FSM states
//   fetch_target_t : which operand buffer a fetch fills
//   idx_width()    : width of an index port for a dimension (min 1 bit)
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fetch_state_t;

  typedef enum logic {
    ROW,
    COL
  } fetch_target_t;

  // A dimension of 1 still gets a 1-bit index port (tied to 0 by the user).
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Combinational operand address generator: addr = base + major*stride + minor.
//   base, major, stride, minor : operands, already zero-extended to ADDR_WIDTH
//   addr                       : resulting word address
module fetch_addr_gen #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] major,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [ADDR_WIDTH-1:0] minor,
  output logic [ADDR_WIDTH-1:0] addr
);

  // Every term is ADDR_WIDTH bits wide, so product and sum wrap modulo
  // 2^ADDR_WIDTH; address overflow simply truncates.
  assign addr = base + major * stride + minor;

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: responder to the control unit's fetch_row/fetch_col
// requests. Gathers row n of A or column m of B (K elements each) from
// word-addressed memory into row/column buffers for the PE array.
//   clk, rst                  : clock, synchronous active-high reset
//   fetch_row/fetch_col, n, m : requests and indices, accepted when !fetch_stall
//   fetch_stall               : busy
//   mem_req/mem_addr/mem_gnt  : read request channel
//   mem_rvalid/mem_rdata      : in-order read response channel
//   row_data/row_valid        : row buffer (element k at [k*DATA_WIDTH +: DATA_WIDTH])
//   col_data/col_valid        : column buffer, same packing
//   protocol_err              : sticky, response seen with no read outstanding
module operand_fetch_unit
  import mm_pkg::*;
#(
  parameter int N          = 4,
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int A_BASE     = 0,
  parameter int B_BASE     = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_row,
  input  logic                      fetch_col,
  input  logic [idx_width(N)-1:0]   n,
  input  logic [idx_width(M)-1:0]   m,
  output logic                      fetch_stall,
  output logic                      mem_req,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [K*DATA_WIDTH-1:0]   row_data,
  output logic                      row_valid,
  output logic [K*DATA_WIDTH-1:0]   col_data,
  output logic                      col_valid,
  output logic                      protocol_err
);

  localparam int NW = idx_width(N);
  localparam int MW = idx_width(M);
  // Counters must be able to hold K itself (k_rcv reaches K at completion).
  localparam int CW = $clog2(K + 1);

  fetch_state_t             state_q, state_d;
  fetch_target_t            target_q, target_d;
  logic [NW-1:0]            n_q, n_d;
  logic [MW-1:0]            m_q, m_d;
  logic                     pending_col_q, pending_col_d;
  logic [CW-1:0]            k_iss_q, k_iss_d;
  logic [CW-1:0]            k_rcv_q, k_rcv_d;
  logic [CW-1:0]            outst_q, outst_d;
  logic [K*DATA_WIDTH-1:0]  row_buf_q, row_buf_d;
  logic [K*DATA_WIDTH-1:0]  col_buf_q, col_buf_d;
  logic                     row_valid_q, row_valid_d;
  logic                     col_valid_q, col_valid_d;
  logic                     protocol_err_q, protocol_err_d;

  logic                     gnt_fire;
  logic                     rsp_ok;
  logic [ADDR_WIDTH-1:0]    ag_base, ag_major, ag_stride, ag_minor, ag_addr;

  // One shared address generator; operands are muxed by the fetch target.
  always_comb begin
    if (target_q == ROW) begin
      ag_base   = ADDR_WIDTH'(A_BASE);
      ag_major  = ADDR_WIDTH'(n_q);
      ag_stride = ADDR_WIDTH'(K);
      ag_minor  = ADDR_WIDTH'(k_iss_q);
    end else begin
      ag_base   = ADDR_WIDTH'(B_BASE);
      ag_major  = ADDR_WIDTH'(k_iss_q);
      ag_stride = ADDR_WIDTH'(M);
      ag_minor  = ADDR_WIDTH'(m_q);
    end
  end

  fetch_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .base  (ag_base),
    .major (ag_major),
    .stride(ag_stride),
    .minor (ag_minor),
    .addr  (ag_addr)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d        = state_q;
    target_d       = target_q;
    n_d            = n_q;
    m_d            = m_q;
    pending_col_d  = pending_col_q;
    k_iss_d        = k_iss_q;
    k_rcv_d        = k_rcv_q;
    row_buf_d      = row_buf_q;
    col_buf_d      = col_buf_q;
    row_valid_d    = row_valid_q;
    col_valid_d    = col_valid_q;
    protocol_err_d = protocol_err_q;

    mem_req  = (state_q == ISSUE);
    gnt_fire = mem_req & mem_gnt;
    // A response is only legal while a granted read is still outstanding.
    rsp_ok   = mem_rvalid & (outst_q != '0);

    if (mem_rvalid && outst_q == '0) protocol_err_d = 1'b1;

    // Grant and response in the same cycle both count.
    outst_d = outst_q + CW'(gnt_fire) - CW'(rsp_ok);

    if (gnt_fire) k_iss_d = k_iss_q + 1'b1;

    if (rsp_ok) begin
      for (int k = 0; k < K; k++) begin
        if (k_rcv_q == CW'(k)) begin
          if (target_q == ROW) row_buf_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          else                 col_buf_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
        end
      end
      k_rcv_d = k_rcv_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fetch_row) begin
          state_d     = ISSUE;
          target_d    = ROW;
          n_d         = n;
          row_valid_d = 1'b0;
          // A simultaneous column request is parked and served after the row.
          if (fetch_col) begin
            pending_col_d = 1'b1;
            m_d           = m;
            col_valid_d   = 1'b0;
          end
        end else if (fetch_col) begin
          state_d     = ISSUE;
          target_d    = COL;
          m_d         = m;
          col_valid_d = 1'b0;
        end
      end
      ISSUE: begin
        if (gnt_fire && k_iss_q == CW'(K - 1)) state_d = WAIT;
      end
      WAIT: begin
        // Complete on the edge that captures the last element.
        if (k_rcv_d == CW'(K)) begin
          if (target_q == ROW) row_valid_d = 1'b1;
          else                 col_valid_d = 1'b1;
          k_iss_d = '0;
          k_rcv_d = '0;
          if (pending_col_q) begin
            state_d       = ISSUE;
            target_d      = COL;
            pending_col_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    if (rst) begin
      state_q        <= IDLE;
      target_q       <= ROW;
      n_q            <= '0;
      m_q            <= '0;
      pending_col_q  <= 1'b0;
      k_iss_q        <= '0;
      k_rcv_q        <= '0;
      outst_q        <= '0;
      // NOTE: the operand buffers are ordinary flops, not a RAM, and their
      // contents are visible outputs, so they are cleared on reset too.
      row_buf_q      <= '0;
      col_buf_q      <= '0;
      row_valid_q    <= 1'b0;
      col_valid_q    <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      n_q            <= n_d;
      m_q            <= m_d;
      pending_col_q  <= pending_col_d;
      k_iss_q        <= k_iss_d;
      k_rcv_q        <= k_rcv_d;
      outst_q        <= outst_d;
      row_buf_q      <= row_buf_d;
      col_buf_q      <= col_buf_d;
      row_valid_q    <= row_valid_d;
      col_valid_q    <= col_valid_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Stall depends only on registered state, never on the fetch_* inputs.
  assign fetch_stall  = (state_q != IDLE) | pending_col_q;
  assign mem_addr     = mem_req ? ag_addr : '0;
  assign row_data     = row_buf_q;
  assign row_valid    = row_valid_q;
  assign col_data     = col_buf_q;
  assign col_valid    = col_valid_q;
  assign protocol_err = protocol_err_q;

endmodule
